// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM
// between two valid/ready requesters with registered read return.
module sram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic              i_req0_we,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  output logic              o_req0_rvalid,
  output logic [DATA_W-1:0] o_req0_rdata,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic              i_req1_we,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_req1_rvalid,
  output logic [DATA_W-1:0] o_req1_rdata,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RD
  } state_t;

  state_t              r_state;
  logic                r_prio;
  logic                r_port;
  logic                r_ce;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;

  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = i_req0_valid & (~i_req1_valid | ~r_prio);
  assign w_grant1 = i_req1_valid & (~i_req0_valid | r_prio);
  assign w_acc0   = w_idle & w_grant0;
  assign w_acc1   = w_idle & w_grant1;

  assign o_req0_ready  = w_acc0;
  assign o_req1_ready  = w_acc1;
  assign o_busy        = ~w_idle;
  assign o_ram_ce      = r_ce;
  assign o_ram_we      = r_we;
  assign o_ram_addr    = r_addr;
  assign o_ram_data    = r_wdata;
  assign o_req0_rvalid = r_rvalid0;
  assign o_req1_rvalid = r_rvalid1;
  assign o_req0_rdata  = r_rdata0;
  assign o_req1_rdata  = r_rdata1;

  // RAM pins double as the command latch; they idle at zero outside ISSUE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_prio    <= 1'b0;
      r_port    <= 1'b0;
      r_ce      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc0 | w_acc1) begin
            r_port  <= w_acc1;
            r_prio  <= ~w_acc1;
            r_ce    <= 1'b1;
            r_we    <= w_acc1 ? i_req1_we : i_req0_we;
            r_addr  <= w_acc1 ? i_req1_addr : i_req0_addr;
            r_wdata <= w_acc1 ? i_req1_wdata : i_req0_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_ce    <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
          r_wdata <= '0;
          r_state <= r_we ? S_IDLE : S_RD;
        end
        S_RD: begin
          if (r_port) begin
            r_rdata1  <= i_ram_data;
            r_rvalid1 <= 1'b1;
          end else begin
            r_rdata0  <= i_ram_data;
            r_rvalid0 <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: shadow-memory model predicts
// grants, RAM pin activity and read returns; a monitor checks them.
module tb_sram_arbiter;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [5:0] a0 = '0, a1 = '0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       rdy0, rdy1, rv0, rv1;
  logic [7:0] rd0, rd1;
  logic       ram_ce, ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_wd;
  logic [7:0] ram_q = '0;
  logic       busy;

  logic [7:0] mem [64];
  logic [7:0] shadow [64];
  logic [7:0] last [2];
  cmd_t       cq0 [$];
  cmd_t       cq1 [$];
  exp_t       sbq [$];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int gap = 0;
  int prio = 0;
  int free_at = 0;
  int iss_cyc = -1;
  int acc_cnt1 = 0;
  cmd_t iss_cmd;
  logic acc0, acc1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wd;
      else ram_q <= mem[ram_addr];
    end
  end

  sram_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(rdy0),
    .i_req0_we(we0), .i_req0_addr(a0),
    .i_req0_wdata(d0), .o_req0_rvalid(rv0),
    .o_req0_rdata(rd0),
    .i_req1_valid(v1), .o_req1_ready(rdy1),
    .i_req1_we(we1), .i_req1_addr(a1),
    .i_req1_wdata(d1), .o_req1_rvalid(rv1),
    .o_req1_rdata(rd1),
    .o_ram_ce(ram_ce), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_data(ram_wd),
    .i_ram_data(ram_q), .o_busy(busy)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("rvalid_both", {31'd0, rv0 & rv1}, 0);
      if (rv0 | rv1) begin
        if (sbq.size() == 0) begin
          chk("rvalid_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("rvalid_port", {31'd0, rv1}, e.port);
          chk("rvalid_cycle", cyc, e.due);
          last[e.port] = e.data;
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("rvalid_missing", 0, 1);
        last[e.port] = e.data;
      end
      chk("rdata0", {24'd0, rd0}, {24'd0, last[0]});
      chk("rdata1", {24'd0, rd1}, {24'd0, last[1]});
    end
  end

  task automatic accept(int p, cmd_t c);
    exp_t e;
    prio = 1 - p;
    iss_cyc = cyc + 1;
    iss_cmd = c;
    if (p == 1) acc_cnt1++;
    if (c.we) begin
      shadow[c.addr] = c.data;
      free_at = cyc + 2;
    end else begin
      e.port = p;
      e.data = shadow[c.addr];
      e.due = cyc + 3;
      sbq.push_back(e);
      free_at = cyc + 3;
    end
  endtask

  task automatic model_eval();
    logic idle, e0, e1;
    cmd_t c;
    idle = (cyc >= free_at);
    e0 = idle & v0 & (!v1 | prio == 0);
    e1 = idle & v1 & (!v0 | prio == 1);
    chk("ready0", {31'd0, rdy0}, {31'd0, e0});
    chk("ready1", {31'd0, rdy1}, {31'd0, e1});
    chk("busy", {31'd0, busy}, {31'd0, !idle});
    if (cyc == iss_cyc) begin
      chk("ram_ce", {31'd0, ram_ce}, 1);
      chk("ram_we", {31'd0, ram_we}, {31'd0, iss_cmd.we});
      chk("ram_addr", {26'd0, ram_addr}, {26'd0, iss_cmd.addr});
      if (iss_cmd.we)
        chk("ram_data", {24'd0, ram_wd}, {24'd0, iss_cmd.data});
    end else begin
      chk("ram_ce_idle", {31'd0, ram_ce}, 0);
    end
    acc0 = e0;
    acc1 = e1;
    if (e0) begin
      c.we = we0; c.addr = a0; c.data = d0;
      accept(0, c);
    end else if (e1) begin
      c.we = we1; c.addr = a1; c.data = d1;
      accept(1, c);
    end
  endtask

  task automatic step();
    cmd_t c;
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
    if (acc0) v0 = 1'b0;
    if (acc1) v1 = 1'b0;
    if (!v0 && cq0.size() > 0 && $urandom_range(99) >= gap) begin
      c = cq0.pop_front();
      v0 = 1'b1; we0 = c.we; a0 = c.addr; d0 = c.data;
    end
    if (!v1 && cq1.size() > 0 && $urandom_range(99) >= gap) begin
      c = cq1.pop_front();
      v1 = 1'b1; we1 = c.we; a1 = c.addr; d1 = c.data;
    end
  endtask

  task automatic drain(int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      done = cq0.size() == 0 && cq1.size() == 0 && !v0 && !v1
             && sbq.size() == 0 && cyc > free_at;
      if (done) break;
      step();
    end
    chk("drain_done", {31'd0, done}, 1);
  endtask

  task automatic push(int p, logic we, logic [5:0] ad,
                      logic [7:0] da);
    cmd_t c;
    c.we = we; c.addr = ad; c.data = da;
    if (p == 0) cq0.push_back(c);
    else cq1.push_back(c);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", {30'd0, rdy1, rdy0}, 0);
    chk("rst_rvalid", {30'd0, rv1, rv0}, 0);
    chk("rst_rdata", {16'd0, rd1, rd0}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ram", {16'd0, ram_ce, ram_we, ram_addr, ram_wd}, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    sbq.delete();
    prio = 0; free_at = 0; iss_cyc = -1;
    last[0] = '0; last[1] = '0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    apply_reset();

    // 1: write then read back on port 0
    gap = 0;
    push(0, 1'b1, 6'd5, 8'hA5);
    push(0, 1'b0, 6'd5, 8'h00);
    drain(50);
    chk("t1_rdata", {24'd0, rd0}, 32'hA5);

    // 2/3: both ports valid together, 8 writes each
    for (int i = 0; i < 8; i++) begin
      push(0, 1'b1, 6'(i), 8'(16 + i));
      push(1, 1'b1, 6'(32 + i), 8'(48 + i));
    end
    drain(100);

    // 4: fill memory from port 0, read all from port 1
    for (int i = 0; i < 64; i++) push(0, 1'b1, 6'(i), 8'(i + 1));
    drain(300);
    for (int i = 0; i < 64; i++) push(1, 1'b0, 6'(i), 8'h00);
    drain(400);
    chk("t4_addr63", {24'd0, rd1}, 32'h40);

    // 5: reset during RD of a port 1 read
    base = acc_cnt1;
    push(1, 1'b0, 6'd9, 8'h00);
    for (int i = 0; i < 20 && acc_cnt1 == base; i++) step();
    chk("t5_accepted", acc_cnt1 - base, 1);
    step();
    apply_reset();
    for (int i = 0; i < 64; i++) shadow[i] = mem[i];
    repeat (4) step();
    push(1, 1'b1, 6'd1, 8'h11);
    push(0, 1'b1, 6'd2, 8'h22);
    drain(50);

    // 6: back-to-back reads on port 0 only
    for (int i = 0; i < 10; i++) push(0, 1'b0, 6'(i * 6), 8'h00);
    drain(100);

    // randomized mixed traffic
    gap = 40;
    for (int i = 0; i < 300; i++) begin
      push(0, 1'($urandom_range(1)), 6'($urandom_range(63)),
           8'($urandom_range(255)));
      push(1, 1'($urandom_range(1)), 6'($urandom_range(63)),
           8'($urandom_range(255)));
    end
    drain(8000);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
